bcd_to_binary_serial: RTL
=========================

# bcd_to_binary_serial

Parametrised multi-digit BCD-to-binary converter for the microwave controller's time-entry path. It accepts a packed NUM_DIGITS-digit BCD word, for example MM:SS keypad entry, over a valid/ready handshake. It accumulates the binary value one digit per clock, most-significant digit first, using acc = acc*10 + digit, and presents the result with a held valid/ready output handshake. It flags any non-decimal nibble (10–15), where the previous single-digit converter silently saturated.

## Interface
Parameters:
- NUM_DIGITS, default 4: number of BCD digits in the input word; must be at least 1.
- BIN_W, default 14: result width; must satisfy 2^BIN_W > 10^NUM_DIGITS − 1. Integration asserts this at elaboration.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- bcd_in  in  4*NUM_DIGITS  packed digits; bits [4*NUM_DIGITS-1 -: 4] hold the MS digit.
- in_valid  in  1  bcd_in is valid.
- in_ready  out  1  block can accept input; high only in IDLE.
- bin_out  out  BIN_W  converted value, unsigned.
- err  out  1  a nibble greater than 9 was present in the accepted word.
- out_valid  out  1  bin_out and err are valid.
- out_ready  in  1  consumer takes the result.

## Operation
- Reset values: FSM in IDLE; in_ready=1, out_valid=0, bin_out=0, err=0; accumulator, shift register and digit counter cleared.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_valid && in_ready captures bcd_in into the shift register.
  - If every nibble is ≤ 9: acc cleared, counter set to NUM_DIGITS−1, go to CONV.
  - If any nibble is > 9: bin_out=0, err=1, go to DONE. No CONV cycles are spent.
- CONV, one digit per cycle, MS digit first:
  - acc ← acc*10 + top nibble, with acc*10 computed as (acc<<3)+(acc<<1) at BIN_W+4 bits and truncated to BIN_W.
  - The register shifts left by 4. The counter decrements.
  - When the counter is 0, the final sum loads bin_out, err=0, go to DONE.
- DONE:
  - out_valid=1.
  - bin_out and err are held stable until out_ready=1.
  - On out_ready, go to IDLE; out_valid drops on that edge.
- in_valid is ignored outside IDLE. Input is not buffered; the producer must hold it until in_ready.
- bin_out keeps its last value in IDLE and CONV. Its value is only meaningful while out_valid=1.
- Truncation at BIN_W never discards set bits when the BIN_W constraint is met.
- The leading zero digit is legal; for example 0x0009 gives 9.

## Timing
- Valid word: out_valid rises NUM_DIGITS cycles after the accept edge. With NUM_DIGITS=4, accept at edge T gives out_valid=1 after edge T+4.
- Invalid word: out_valid rises 1 cycle after the accept edge.
- Output handshake:
  - out_ready high while DONE is entered: out_valid lasts exactly 1 cycle, then IDLE.
  - in_ready returns high the cycle after the output handshake.
  - Minimum back-to-back period is NUM_DIGITS+2 cycles.
- out_ready outside DONE has no effect. The input and output handshakes never coincide in the same cycle.
- Reset asserted mid-CONV or mid-DONE:
  - All outputs go to reset values immediately, without waiting for a clock edge.
  - The partial conversion is discarded.
  - The first accept after rst_n deasserts behaves as after power-up.

## Structure
- Package bcd_pkg:
  - state enum (IDLE, CONV, DONE);
  - constant BCD_DIGIT_MAX = 4'd9;
  - function returning the minimum BIN_W for a given digit count, used by the elaboration assertion.
- One natural sub-module, bcd_digit_mac: combinational acc*10 + digit, parametrised on BIN_W. It is reused by any future parallel variant.
- The top level holds the FSM, shift register, counter, accumulator and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, BIN_W=14.
- Reset mid-operation: assert rst_n=0 during CONV → in_ready=1, out_valid=0, bin_out=0, err=0 with no clock edge. After release, 0x0059 → bin_out=59.
- Basic conversion: 0x1234 with in_valid, out_ready=1 → out_valid high exactly 4 cycles after accept; bin_out=1234 (0x4D2); err=0; out_valid lasts 1 cycle.
- Boundaries: 0x9999 → 9999 (0x270F); 0x0000 → 0; 0x0001 → 1. All have err=0 and latency 4.
- Invalid digit: 0x12A4 → out_valid 1 cycle after accept, err=1, bin_out=0. A following 0x0100 → 100 with err=0.
- Backpressure: 0x0730 with out_ready=0 for 5 cycles → bin_out=730 stable and out_valid=1 throughout. in_ready=0, and an in_valid pulse carrying 0x1111 is not accepted. out_ready=1 → IDLE next cycle.
- Back-to-back: in_valid held high with 0x0001 then 0x0002, out_ready=1 → two results, 1 then 2, exactly 6 cycles apart.

Source files
------------

// File: rtl/bcd_to_binary_serial_pkg.sv
// bcd_pkg: shared types and constants for the serial BCD-to-binary converter.
//   state_e        : converter FSM states (IDLE, CONV, DONE)
//   BCD_DIGIT_MAX  : largest legal decimal nibble
//   min_bin_w()    : minimum result width able to hold 10^digits - 1
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_DONE
  } state_e;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  function automatic int unsigned min_bin_w(input int unsigned digits);
    longint unsigned max_val;
    int unsigned     width;
    max_val = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      max_val = max_val * 64'd10;
    end
    max_val = max_val - 64'd1;
    width   = 1;
    while ((max_val >> width) != 64'd0) begin
      width++;
    end
    return width;
  endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// bcd_digit_mac: combinational decimal multiply-accumulate, acc*10 + digit.
//   acc_in  : running binary value (BIN_W bits)
//   digit   : next decimal digit, assumed 0..9
//   acc_out : acc_in*10 + digit, truncated to BIN_W bits
module bcd_digit_mac #(
  parameter int unsigned BIN_W = 14
) (
  input  logic [BIN_W-1:0] acc_in,
  input  logic [3:0]       digit,
  output logic [BIN_W-1:0] acc_out
);

  // x10 as (x<<3)+(x<<1) evaluated at BIN_W+4 bits so no carry is lost
  // before the final truncation.
  always_comb begin
    acc_out = BIN_W'(({4'b0000, acc_in} << 3)
                   + ({4'b0000, acc_in} << 1)
                   + {{BIN_W{1'b0}}, digit});
  end

endmodule

// File: rtl/bcd_to_binary_serial.sv
// bcd_to_binary_serial: converts a packed NUM_DIGITS-digit BCD word to binary,
// one digit per clock, most-significant digit first.
//   clk, rst_n : clock, asynchronous active-low reset
//   bcd_in     : packed BCD word, MS digit in the top nibble
//   in_valid   : bcd_in valid
//   in_ready   : converter idle and able to accept a word
//   bin_out    : converted value (meaningful while out_valid)
//   err        : accepted word held a nibble above 9 (bin_out is then 0)
//   out_valid  : result available, held until out_ready
//   out_ready  : consumer takes the result
module bcd_to_binary_serial
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BIN_W      = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [BIN_W-1:0]        bin_out,
  output logic                    err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int unsigned WORD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1) begin : g_bad_digits
    $fatal(1, "bcd_to_binary_serial: NUM_DIGITS must be at least 1");
  end
  if (BIN_W < min_bin_w(NUM_DIGITS)) begin : g_bad_width
    $fatal(1, "bcd_to_binary_serial: BIN_W too small for NUM_DIGITS");
  end

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [BIN_W-1:0]    acc_q,   acc_d;
  logic [BIN_W-1:0]    bin_q,   bin_d;
  logic                err_q,   err_d;

  logic                bad_digit;
  logic [BIN_W-1:0]    mac_out;

  bcd_digit_mac #(
    .BIN_W (BIN_W)
  ) u_mac (
    .acc_in  (acc_q),
    .digit   (shreg_q[WORD_W-1 -: 4]),
    .acc_out (mac_out)
  );

  // Whole-word validity is checked at accept time so a bad word skips CONV.
  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > BCD_DIGIT_MAX) begin
        bad_digit = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bin_d   = bin_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shreg_d = bcd_in;
          if (bad_digit) begin
            bin_d   = '0;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            acc_d   = '0;
            cnt_d   = CNT_LAST;
            state_d = ST_CONV;
          end
        end
      end
      ST_CONV: begin
        acc_d   = mac_out;
        shreg_d = shreg_q << 4;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          cnt_d   = '0;
          bin_d   = mac_out;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    bin_out   = bin_q;
    err       = err_q;
  end

endmodule
